// File: rtl/debounce_bank.sv
// Bank of independent input debouncers. Each channel has a two-flop synchronizer, a saturating
// stability counter and a registered debounced level with one-cycle rise/fall pulses.
module debounce_bank #(
  parameter int   CH            = 4,
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          sample_en,
  input  logic [CH-1:0] data_in,
  output logic [CH-1:0] data_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_change
);

  localparam int            CW      = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CH-1:0] RST_VEC = {CH{RESET_VAL}};

  logic [CH-1:0] ff1;
  logic [CH-1:0] ff2;
  logic [CH-1:0] state;
  logic [CW-1:0] cnt      [CH];
  logic [CW-1:0] cnt_next [CH];
  logic [CH-1:0] accept;
  logic [CH-1:0] rise_next;
  logic [CH-1:0] fall_next;

  // Per-channel qualification: any sample that agrees with the accepted level restarts the count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    accept = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_next[i] = cnt[i];
      if (ff2[i] == state[i]) begin
        cnt_next[i] = '0;
      end else if (sample_en) begin
        if (cnt[i] == CNT_MAX) begin
          accept[i]   = 1'b1;
          cnt_next[i] = '0;
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Acceptance only happens on a mismatch, so ff2 alone gives the edge direction.
  assign rise_next = accept & ff2;
  assign fall_next = accept & ~ff2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ff1        <= RST_VEC;
      ff2        <= RST_VEC;
      state      <= RST_VEC;
      rise       <= '0;
      fall       <= '0;
      any_change <= 1'b0;
      // NOTE: the counter array is reset explicitly; reset must discard any in-flight qualification.
      for (int i = 0; i < CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so ff2 samples the pre-edge ff1 (true two-stage synchronizer).
      ff1        <= data_in;
      ff2        <= ff1;
      state      <= (state & ~accept) | (ff2 & accept);
      cnt        <= cnt_next;
      rise       <= rise_next;
      fall       <= fall_next;
      any_change <= |(rise_next | fall_next);
    end
  end

  assign data_out = state;

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CH, default 4, number of independent input channels (1..32).
REQ-002 Parameter STABLE_CYCLES, default 16, sample_en-qualified cycles an input must hold a new level before it is accepted (2..65535).
REQ-003 Parameter RESET_VAL, default 1'b0, debounced level every channel takes in reset.
REQ-004 Counter width SHALL be derived internally as clog2(STABLE_CYCLES), minimum 1; not a user parameter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 sample_en  input  1  qualifier that advances stability counters; tie 1 for per-clock counting.
REQ-008 data_in  input  CH  raw asynchronous inputs, one bit per channel.
REQ-009 data_out  output  CH  debounced levels, registered.
REQ-010 rise  output  CH  one-cycle pulse when the data_out bit goes 0->1.
REQ-011 fall  output  CH  one-cycle pulse when the data_out bit goes 1->0.
REQ-012 any_change  output  1  registered OR of rise|fall over all channels, same cycle as the pulses.

Function
REQ-013 Each channel SHALL have a two-flop synchronizer (ff1<-data_in, ff2<-ff1), always enabled, independent of sample_en.
REQ-014 Each channel SHALL have a stability counter cnt and a state bit state (= data_out bit); channels SHALL NOT interact.
REQ-015 Mismatch per channel = ff2 != state.
REQ-016 No mismatch: cnt SHALL clear to 0 on the next edge, regardless of sample_en.
REQ-017 Mismatch, sample_en=0: cnt and state SHALL hold.
REQ-018 Mismatch, sample_en=1, cnt < STABLE_CYCLES-1: cnt SHALL increment by 1.
REQ-019 Mismatch, sample_en=1, cnt == STABLE_CYCLES-1: state SHALL take ff2 and cnt SHALL clear to 0, same edge.
REQ-020 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-021 A bounce (ff2 returns to state before acceptance) SHALL clear cnt; counting restarts from 0 on the next mismatch.
REQ-022 With sample_en=1 constantly, data_out SHALL change on the (STABLE_CYCLES+2)-th rising edge that samples the new level, counting the first sampling edge as 1.
REQ-023 rise/fall SHALL be registered, asserted in the same cycle data_out first shows the new value, high for exactly one cycle.
REQ-024 rise and fall for one channel SHALL never be high together; different channels may pulse in the same cycle.
REQ-025 Input pulses shorter than STABLE_CYCLES qualified samples SHALL produce no data_out change and no pulse.

Reset
REQ-026 reset_n low SHALL asynchronously force: ff1, ff2, state to RESET_VAL per channel; cnt to 0; rise, fall, any_change to 0.
REQ-027 Reset mid-count SHALL discard progress; after release, counting starts from 0.
REQ-028 Reset release SHALL produce no rise/fall pulse unless an input differs from RESET_VAL for the full qualification time after release.

Verification
REQ-029 CH=4, STABLE_CYCLES=4, sample_en=1; data_in[0] 0->1 held -> data_out[0]=1 and rise[0]=1 for one cycle at edge 6; other bits stay 0.
REQ-030 Same config; data_in[1] high for 3 cycles then low -> data_out[1], rise[1], fall[1], any_change remain 0 throughout.
REQ-031 Same config; data_in[2] high 3 cycles, low 1, high held -> acceptance 6 edges after the final rising level, not earlier.
REQ-032 sample_en pulsed once every 4 clocks, data_in[3] 0->1 held -> data_out[3] rises after 4 qualified samples plus sync delay (approx. 16-20 clocks); cnt holds between pulses.
REQ-033 data_in=4'b1111 held for 3 cycles, reset_n pulsed low -> all outputs 0 asynchronously; after release, acceptance takes a full 6 edges from release.
REQ-034 RESET_VAL=1, data_in=all 1 through reset release -> no pulses; later data_in[0] 1->0 held -> fall[0] and any_change pulse once, data_out=4'b1110.
